// File: rtl/regfile_feed_sched.sv
// -----------------------------------------------------------------------------
// regfile_feed_sched
//
// Register file for the pet-feeder core with a built-in feeding scheduler.
// DEPTH x WIDTH registers, two combinational read ports, one write port with
// write-through bypass. A block of registers holds N_ALARMS schedule slots
// (hour, min, ampm). Each slot is compared against the live time, and a
// feed-duration state machine drives the dispenser without CPU polling.
//
// Special registers:
//   0                      hard-wired zero, writes ignored
//   TIME_BASE .. +2        read: registered mirror of cur_hour/cur_min/cur_ampm
//                          write: not stored, pulses time_set_en[i] next cycle
//   DUR_REG                feed duration in tick_1hz periods (plain storage)
//   STATUS_REG             read-only {count[15:8], source[4:1], feed_active[0]}
//   FEED_REG               write of a nonzero value triggers a manual feed,
//                          not stored, always reads 0
//
// Ports:
//   clock              system clock, rising edge
//   ctrl_reset         asynchronous active-low reset
//   ctrl_writeEnable   write strobe
//   ctrl_writeReg      write address
//   data_writeReg      write data
//   ctrl_readRegA/B    read addresses
//   data_readRegA/B    combinational read data
//   cur_hour/min/ampm  current time from the clock module
//   tick_1hz           one-cycle pulse per second
//   time_set_en        one-cycle pulse per time field written (registered)
//   time_set_data      low byte of the write data, valid with time_set_en
//   feed_active        high while dispensing (registered)
//   feed_start         one-cycle pulse when a feed begins (registered)
// -----------------------------------------------------------------------------
module regfile_feed_sched #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int N_ALARMS   = 3,
    parameter int ALARM_BASE = 10,
    parameter int TIME_BASE  = 19,
    parameter int DUR_REG    = 22,
    parameter int STATUS_REG = 23,
    parameter int FEED_REG   = 24,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]  data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]  data_readRegA,
    output logic [WIDTH-1:0]  data_readRegB,
    input  logic [7:0]        cur_hour,
    input  logic [7:0]        cur_min,
    input  logic              cur_ampm,
    input  logic              tick_1hz,
    output logic [2:0]        time_set_en,
    output logic [7:0]        time_set_data,
    output logic              feed_active,
    output logic              feed_start
);

    localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] TIME_A0  = ADDR_W'(TIME_BASE);
    localparam logic [ADDR_W-1:0] TIME_A1  = ADDR_W'(TIME_BASE + 1);
    localparam logic [ADDR_W-1:0] TIME_A2  = ADDR_W'(TIME_BASE + 2);
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_REG);
    localparam logic [ADDR_W-1:0] FEED_A   = ADDR_W'(FEED_REG);
    localparam logic [WIDTH-1:0]  ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]        SRC_MANUAL = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_FEEDING = 1'b1
    } state_t;

    // Storage and state
    logic [WIDTH-1:0]  regs_r [DEPTH];
    logic [7:0]        hour_m_r;
    logic [7:0]        min_m_r;
    logic              ampm_m_r;
    logic [N_ALARMS-1:0] fired_r;
    state_t            state_r;
    logic [WIDTH-1:0]  counter_r;
    logic              feed_start_r;
    logic              feed_active_r;
    logic [7:0]        count_r;
    logic [3:0]        source_r;
    logic [2:0]        time_set_en_r;
    logic [7:0]        time_set_data_r;

    // Combinational helpers
    logic [N_ALARMS-1:0] match_s;
    logic [N_ALARMS-1:0] fire_s;
    logic              manual_s;
    logic              trig_s;
    logic [3:0]        src_s;
    logic [2:0]        time_wr_s;
    logic [WIDTH-1:0]  status_s;
    logic [WIDTH-1:0]  dur_s;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  counter_nxt_s;
    logic              feed_start_nxt_s;
    logic [7:0]        count_nxt_s;
    logic [3:0]        source_nxt_s;

    // Addresses whose storage is never written by the write port.
    function automatic logic is_read_only(input logic [ADDR_W-1:0] a);
        return (a == ZERO_A)  || (a == TIME_A0)  || (a == TIME_A1) ||
               (a == TIME_A2) || (a == STATUS_A) || (a == FEED_A);
    endfunction

    // Read mux shared by both ports; bypass only reaches ordinary storage.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] r;
        r = ZERO_W;
        if (a == ZERO_A) begin
            r = ZERO_W;
        end else if (a == TIME_A0) begin
            r = {{(WIDTH-8){1'b0}}, hour_m_r};
        end else if (a == TIME_A1) begin
            r = {{(WIDTH-8){1'b0}}, min_m_r};
        end else if (a == TIME_A2) begin
            r = {{(WIDTH-1){1'b0}}, ampm_m_r};
        end else if (a == STATUS_A) begin
            r = status_s;
        end else if (a == FEED_A) begin
            r = ZERO_W;
        end else if (ctrl_writeEnable && (ctrl_writeReg == a)) begin
            r = data_writeReg;
        end else begin
            r = regs_r[a];
        end
        return r;
    endfunction

    assign status_s = {{(WIDTH-16){1'b0}}, count_r, 3'b000, source_r, feed_active_r};
    assign dur_s    = regs_r[DUR_REG];
    assign manual_s = ctrl_writeEnable && (ctrl_writeReg == FEED_A) && (data_writeReg != ZERO_W);
    assign time_wr_s = {ctrl_writeEnable && (ctrl_writeReg == TIME_A2),
                        ctrl_writeEnable && (ctrl_writeReg == TIME_A1),
                        ctrl_writeEnable && (ctrl_writeReg == TIME_A0)};

    // Combinational read ports
    always_comb begin
        data_readRegA = read_port(ctrl_readRegA);
        data_readRegB = read_port(ctrl_readRegB);
    end

    // Per-slot comparators; an all-zero hour register disarms the slot.
    for (genvar k = 0; k < N_ALARMS; k++) begin : g_alarm
        localparam int HA = ALARM_BASE + 3 * k;
        assign match_s[k] = (regs_r[HA] != ZERO_W) &&
                            (regs_r[HA]     == {{(WIDTH-8){1'b0}}, cur_hour}) &&
                            (regs_r[HA + 1] == {{(WIDTH-8){1'b0}}, cur_min}) &&
                            (regs_r[HA + 2][0] == cur_ampm);
    end

    // A slot fires only on the first cycle of its matching window.
    assign fire_s = match_s & ~fired_r;

    // Trigger arbitration: manual first, then the lowest-numbered slot.
    always_comb begin
        trig_s = 1'b0;
        src_s  = 4'd0;
        if (manual_s) begin
            trig_s = 1'b1;
            src_s  = SRC_MANUAL;
        end else if (|fire_s) begin
            trig_s = 1'b1;
            for (int k = N_ALARMS - 1; k >= 0; k--) begin
                if (fire_s[k]) begin
                    src_s = 4'(k);
                end else begin
                    src_s = src_s;
                end
            end
        end else begin
            trig_s = 1'b0;
            src_s  = 4'd0;
        end
    end

    // Register storage write port
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= ZERO_W;
            end
        end else if (ctrl_writeEnable && !is_read_only(ctrl_writeReg)) begin
            regs_r[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Time mirror and time-set pulse generation
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            hour_m_r        <= 8'h00;
            min_m_r         <= 8'h00;
            ampm_m_r        <= 1'b0;
            time_set_en_r   <= 3'b000;
            time_set_data_r <= 8'h00;
        end else begin
            hour_m_r        <= cur_hour;
            min_m_r         <= cur_min;
            ampm_m_r        <= cur_ampm;
            time_set_en_r   <= time_wr_s;
            time_set_data_r <= (|time_wr_s) ? data_writeReg[7:0] : 8'h00;
        end
    end

    // Fired latches follow the match so they clear when the minute moves on;
    // they keep tracking even while a feed is in progress.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            fired_r <= {N_ALARMS{1'b0}};
        end else begin
            fired_r <= match_s;
        end
    end

    // Feed FSM next-state and status updates
    always_comb begin
        state_nxt_s      = state_r;
        counter_nxt_s    = counter_r;
        feed_start_nxt_s = 1'b0;
        count_nxt_s      = count_r;
        source_nxt_s     = source_r;
        case (state_r)
            ST_IDLE: begin
                if (trig_s && (dur_s != ZERO_W)) begin
                    state_nxt_s      = ST_FEEDING;
                    counter_nxt_s    = dur_s;
                    feed_start_nxt_s = 1'b1;
                    count_nxt_s      = count_r + 8'd1;
                    source_nxt_s     = src_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FEEDING: begin
                if (tick_1hz) begin
                    // <= also catches a corrupted zero count and exits cleanly
                    if (counter_r <= ONE_W) begin
                        state_nxt_s   = ST_IDLE;
                        counter_nxt_s = ZERO_W;
                    end else begin
                        counter_nxt_s = counter_r - ONE_W;
                    end
                end else begin
                    counter_nxt_s = counter_r;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                counter_nxt_s = ZERO_W;
            end
        endcase
    end

    // Feed FSM state and registered outputs
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_r       <= ST_IDLE;
            counter_r     <= ZERO_W;
            feed_start_r  <= 1'b0;
            feed_active_r <= 1'b0;
            count_r       <= 8'h00;
            source_r      <= 4'h0;
        end else begin
            state_r       <= state_nxt_s;
            counter_r     <= counter_nxt_s;
            feed_start_r  <= feed_start_nxt_s;
            feed_active_r <= (state_nxt_s == ST_FEEDING);
            count_r       <= count_nxt_s;
            source_r      <= source_nxt_s;
        end
    end

    assign time_set_en   = time_set_en_r;
    assign time_set_data = time_set_data_r;
    assign feed_active   = feed_active_r;
    assign feed_start    = feed_start_r;

endmodule

// File: tb/tb_regfile_feed_sched.sv
// -----------------------------------------------------------------------------
// Self-checking bench for regfile_feed_sched: a table of register-file
// vectors, a randomized phase against an array-based reference model, and
// hand-written sequences for the alarm/feed/reset corner cases.
// -----------------------------------------------------------------------------
module tb_regfile_feed_sched;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic [7:0]  cur_hour;
    logic [7:0]  cur_min;
    logic        cur_ampm;
    logic        tick_1hz;
    logic [2:0]  time_set_en;
    logic [7:0]  time_set_data;
    logic        feed_active;
    logic        feed_start;

    int checks = 0;
    int errors = 0;
    int fs_cnt = 0;

    regfile_feed_sched dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .cur_hour         (cur_hour),
        .cur_min          (cur_min),
        .cur_ampm         (cur_ampm),
        .tick_1hz         (tick_1hz),
        .time_set_en      (time_set_en),
        .time_set_data    (time_set_data),
        .feed_active      (feed_active),
        .feed_start       (feed_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic cycle();
        @(posedge clock);
        #1;
        if (feed_start === 1'b1) fs_cnt++;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = a;
        data_writeReg    = d;
        cycle();
        ctrl_writeEnable = 1'b0;
        data_writeReg    = 32'h0;
    endtask

    task automatic do_reset();
        ctrl_reset = 1'b0;
        cycle();
        cycle();
        ctrl_reset = 1'b1;
        cycle();
    endtask

    // Deliver tick_1hz every fourth cycle until the feed ends; returns the
    // number of ticks seen while dispensing.
    task automatic run_feed(output int ticks);
        logic act;
        ticks = 0;
        for (int i = 0; i < 200 && feed_active; i++) begin
            tick_1hz = (i % 4 == 3);
            act = feed_active;
            cycle();
            if (tick_1hz && act) ticks++;
        end
        tick_1hz = 1'b0;
    endtask

    // Reference model for the randomized phase.
    logic [31:0] mem [32];
    logic [7:0]  prev_min;
    logic        prev_ampm;
    logic [2:0]  exp_tse;
    logic [7:0]  exp_tsd;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0)  return 32'h0;
        if (a == 5'd19) return 32'h0;                 // cur_hour held at 0
        if (a == 5'd20) return {24'h0, prev_min};
        if (a == 5'd21) return {31'h0, prev_ampm};
        if (a == 5'd23) return 32'h0;                 // no feed ever runs here
        if (a == 5'd24) return 32'h0;
        if (ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
        return mem[a];
    endfunction

    initial begin
        int ticks;
        int snap;

        ctrl_reset = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg = 5'd0;
        data_writeReg = 32'h0;
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
        cur_hour = 8'd0;
        cur_min = 8'd0;
        cur_ampm = 1'b0;
        tick_1hz = 1'b0;

        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'h00001234, 5'd7,  5'd5,  32'h00001234, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd1,  32'h00001234, 32'h0};
        vecs[6]  = '{1'b1, 5'd23, 32'hFFFFFFFF, 5'd23, 5'd23, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd23, 5'd7,  32'h0,        32'h00001234};
        vecs[8]  = '{1'b1, 5'd24, 32'h0,        5'd24, 5'd24, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd7,  32'hA5A5A5A5, 32'h00001234};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[11] = '{1'b1, 5'd7,  32'hCAFEF00D, 5'd7,  5'd9,  32'hCAFEF00D, 32'hA5A5A5A5};

        // ---- reset state ----
        do_reset();
        chk("reset_feed_active", {31'h0, feed_active}, 32'h0);
        chk("reset_feed_start", {31'h0, feed_start}, 32'h0);
        chk("reset_time_set_en", {29'h0, time_set_en}, 32'h0);

        // ---- table-driven register file vectors ----
        for (int i = 0; i < 12; i++) begin
            ctrl_writeEnable = vecs[i].we;
            ctrl_writeReg    = vecs[i].wa;
            data_writeReg    = vecs[i].wd;
            ctrl_readRegA    = vecs[i].ra;
            ctrl_readRegB    = vecs[i].rb;
            #1;
            chk($sformatf("vec%0d_A", i), data_readRegA, vecs[i].ea);
            chk($sformatf("vec%0d_B", i), data_readRegB, vecs[i].eb);
            cycle();
        end
        ctrl_writeEnable = 1'b0;

        // ---- randomized phase against the reference model ----
        do_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        prev_min = 8'd0;
        prev_ampm = 1'b0;
        exp_tse = 3'b000;
        exp_tsd = 8'h00;
        fs_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            ctrl_writeEnable = 1'($urandom_range(0, 1));
            ctrl_writeReg    = 5'($urandom_range(0, 31));
            data_writeReg    = $urandom;
            if (ctrl_writeReg == 5'd24) data_writeReg = 32'h0;
            ctrl_readRegA    = ($urandom_range(0, 3) == 0) ? ctrl_writeReg : 5'($urandom_range(0, 31));
            ctrl_readRegB    = 5'($urandom_range(0, 31));
            cur_min          = 8'($urandom_range(0, 59));
            cur_ampm         = 1'($urandom_range(0, 1));
            #1;
            chk("rand_A", data_readRegA, model_read(ctrl_readRegA));
            chk("rand_B", data_readRegB, model_read(ctrl_readRegB));
            chk("rand_time_set_en", {29'h0, time_set_en}, {29'h0, exp_tse});
            if (exp_tse != 3'b000) chk("rand_time_set_data", {24'h0, time_set_data}, {24'h0, exp_tsd});
            // advance the model to the coming edge
            if (ctrl_writeEnable && !(ctrl_writeReg inside {5'd0, 5'd19, 5'd20, 5'd21, 5'd23, 5'd24}))
                mem[ctrl_writeReg] = data_writeReg;
            exp_tse = 3'b000;
            if (ctrl_writeEnable && ctrl_writeReg >= 5'd19 && ctrl_writeReg <= 5'd21)
                exp_tse = 3'b001 << (ctrl_writeReg - 5'd19);
            exp_tsd = data_writeReg[7:0];
            prev_min = cur_min;
            prev_ampm = cur_ampm;
            cycle();
        end
        ctrl_writeEnable = 1'b0;
        chk("rand_no_feed", fs_cnt, 0);

        // ---- slot 1 alarm at 7:30 PM, duration 3 ----
        cur_hour = 8'd0; cur_min = 8'd0; cur_ampm = 1'b0;
        do_reset();
        wr(5'd22, 32'd3);
        wr(5'd13, 32'd7);
        wr(5'd14, 32'd30);
        wr(5'd15, 32'd1);
        fs_cnt = 0;
        cur_hour = 8'd7; cur_min = 8'd30; cur_ampm = 1'b1;
        cycle();
        chk("alarm1_feed_start", {31'h0, feed_start}, 32'h1);
        chk("alarm1_feed_active", {31'h0, feed_active}, 32'h1);
        ctrl_readRegA = 5'd23;
        ctrl_readRegB = 5'd19;
        #1;
        chk("alarm1_status_active", data_readRegA, 32'h00000103);
        chk("alarm1_hour_mirror", data_readRegB, 32'd7);
        run_feed(ticks);
        chk("alarm1_ticks", ticks, 3);
        chk("alarm1_done", {31'h0, feed_active}, 32'h0);
        chk("alarm1_status_done", data_readRegA, 32'h00000102);
        for (int i = 0; i < 40; i++) begin
            tick_1hz = (i % 4 == 3);
            cycle();
        end
        tick_1hz = 1'b0;
        chk("alarm1_single_feed", fs_cnt, 1);

        // ---- slots 0 and 2 both at 8:00 AM, duration 2 ----
        cur_hour = 8'd0; cur_min = 8'd0; cur_ampm = 1'b0;
        do_reset();
        wr(5'd10, 32'd8); wr(5'd11, 32'd0); wr(5'd12, 32'd0);
        wr(5'd16, 32'd8); wr(5'd17, 32'd0); wr(5'd18, 32'd0);
        wr(5'd22, 32'd2);
        fs_cnt = 0;
        cur_hour = 8'd8;
        cycle();
        chk("dual_feed_start", {31'h0, feed_start}, 32'h1);
        ctrl_readRegA = 5'd23;
        #1;
        chk("dual_status_src0", data_readRegA, 32'h00000101);
        wr(5'd24, 32'd1);               // manual trigger while feeding
        chk("busy_manual_ignored", fs_cnt, 1);
        chk("busy_status_same", data_readRegA, 32'h00000101);
        run_feed(ticks);
        chk("dual_ticks", ticks, 2);
        chk("dual_single_feed", fs_cnt, 1);

        // ---- manual feed after completion, then zero duration ----
        wr(5'd24, 32'd1);
        chk("manual_feed_start", {31'h0, feed_start}, 32'h1);
        chk("manual_status", data_readRegA, 32'h0000021F);
        wr(5'd22, 32'd7);               // must not stretch the running feed
        run_feed(ticks);
        chk("manual_ticks", ticks, 2);
        wr(5'd22, 32'd0);
        snap = fs_cnt;
        wr(5'd24, 32'd1);
        cycle();
        cycle();
        chk("zero_dur_no_feed", fs_cnt, snap);
        chk("zero_dur_idle", {31'h0, feed_active}, 32'h0);
        chk("zero_dur_status", data_readRegA, 32'h0000021E);

        // ---- time set pulse ----
        wr(5'd20, 32'h0000000B);
        chk("time_set_en_pulse", {29'h0, time_set_en}, 32'h2);
        chk("time_set_data", {24'h0, time_set_data}, 32'h0B);
        cycle();
        chk("time_set_en_clear", {29'h0, time_set_en}, 32'h0);

        // ---- asynchronous reset mid-feed ----
        wr(5'd22, 32'd5);
        wr(5'd24, 32'd1);
        chk("pre_reset_active", {31'h0, feed_active}, 32'h1);
        #2;
        ctrl_reset = 1'b0;
        #1;
        chk("async_reset_active", {31'h0, feed_active}, 32'h0);
        chk("async_reset_status", data_readRegA, 32'h0);
        cycle();
        ctrl_reset = 1'b1;
        cycle();
        chk("post_reset_idle", {31'h0, feed_active}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_feed_sched.md
Name: regfile_feed_sched

Overview:
- Parametrised successor to the CPU register file for the pet-feeder core: DEPTH x WIDTH registers, two combinational read ports and one write port, with write-through bypass.
- Generalises the fixed hour/min/ampm schedule registers to N_ALARMS slots.
- Adds a per-slot alarm comparator and a feed-duration state machine that drives the dispenser directly, without CPU polling.

Parameters:
- WIDTH, 32, data width of every register.
- DEPTH, 32, register count; ADDR_W = clog2(DEPTH).
- N_ALARMS, 3, number of schedule slots; slot k uses registers ALARM_BASE+3k (hour), +3k+1 (min), +3k+2 (ampm).
- ALARM_BASE, 10, first alarm register index.
- TIME_BASE, 19, index of the read-only hour, min, ampm mirrors (TIME_BASE .. TIME_BASE+2).
- DUR_REG, 22, feed duration in tick_1hz periods.
- STATUS_REG, 23, read-only status.
- FEED_REG, 24, manual feed trigger.

Ports:
- clock  in  1  system clock, rising edge.
- ctrl_reset  in  1  asynchronous, active-low reset; 0 = reset.
- ctrl_writeEnable  in  1  write strobe.
- ctrl_writeReg  in  ADDR_W  write address.
- data_writeReg  in  WIDTH  write data.
- ctrl_readRegA  in  ADDR_W  read address, port A.
- ctrl_readRegB  in  ADDR_W  read address, port B.
- data_readRegA  out  WIDTH  read data, port A (combinational).
- data_readRegB  out  WIDTH  read data, port B (combinational).
- cur_hour  in  8  current hour, 1-12, from the clock module.
- cur_min  in  8  current minute, 0-59.
- cur_ampm  in  1  current half-day: 0 = AM, 1 = PM.
- tick_1hz  in  1  one-cycle pulse per second.
- time_set_en  out  3  one-cycle pulse per time field (bit0 hour, bit1 min, bit2 ampm) on a write to TIME_BASE+i.
- time_set_data  out  8  data_writeReg[7:0], valid with time_set_en.
- feed_active  out  1  high while dispensing.
- feed_start  out  1  one-cycle pulse when a feed begins.

Behaviour:
- Reset (ctrl_reset = 0, asynchronous): all registers 0, FSM IDLE, counter 0, fired latches 0, all outputs 0.
- Register 0 reads 0; writes to it are ignored.
- Write: register updates at the posedge when ctrl_writeEnable = 1.
- Bypass: a read address equal to ctrl_writeReg while ctrl_writeEnable = 1 returns data_writeReg the same cycle. Not applied to register 0 or to read-only registers.
- TIME_BASE..+2: reads return zero-extended cur_hour / cur_min / cur_ampm, registered one cycle. A write does not store; it pulses time_set_en[i] the next cycle with time_set_data.
- STATUS_REG is read-only; writes are ignored. Fields: [0] feed_active; [4:1] last source (0..N_ALARMS-1 = alarm slot, 15 = manual); [15:8] feed count, wraps at 255.
- Alarm slot k is armed when its hour register is nonzero.
- match_k = armed && hour == cur_hour && min == cur_min && ampm[0] == cur_ampm.
- fire_k = match_k && !fired_k. fired_k sets on match_k and clears when match_k falls, so each slot fires once per matching minute.
- Manual trigger: a write of a nonzero value to FEED_REG. The register does not store (reads 0).
- FSM IDLE:
  - Any trigger with DUR_REG != 0 -> FEEDING. counter <= DUR_REG; feed_start pulses; count increments; last source updates.
  - Trigger with DUR_REG == 0: stay IDLE, no pulse, status unchanged.
- FSM FEEDING:
  - feed_active = 1.
  - Each tick_1hz decrements counter; on the tick where counter == 1 -> IDLE (feed_active low the next cycle).
  - Triggers are ignored, but fired latches still set (a missed alarm is not retried).
- Priority: multiple alarms firing in the same cycle -> lowest slot index wins; manual trigger has priority over alarms.
- Writing DUR_REG during FEEDING does not affect the current feed.
- Reset mid-feed: immediate IDLE, feed_active = 0.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 -> r5 reads 0xDEADBEEF on A and B; a write to r0 leaves r0 reading 0.
- Read r7 on port A while writing 0x1234 to r7 in the same cycle -> data_readRegA = 0x1234 that cycle.
- DUR_REG = 3, slot 1 = {7, 30, PM}, drive cur = 7:30 PM -> feed_start pulses once; feed_active high for exactly 3 tick_1hz periods; STATUS = feed_active bit 0, source 1, count 1; cur held for 10 more ticks -> no second feed.
- Slots 0 and 2 both = 8:00 AM, DUR_REG = 2, cur = 8:00 AM -> one feed, source 0.
- During FEEDING, write 1 to FEED_REG -> ignored; after completion, write 1 to FEED_REG -> new feed, source 15; DUR_REG = 0 then trigger -> no feed.
- Write 0x0B to TIME_BASE+1 -> time_set_en = 3'b010 for one cycle with time_set_data = 0x0B; drop ctrl_reset during FEEDING -> feed_active = 0 immediately.
